can_transmitter: RTL and testbench

- CAN 2.0A/B frame serializer. It is the transmit counterpart of the CAN receive path in the controller.
- Takes a latched frame (ID, EXT, RTR, DLC, 8 data bytes) and drives CANTX bit by bit on the shared bit-timing strobes. Handles bit stuffing, CRC-15, arbitration, ACK check and error-frame signalling.
- Sits beside the receiver and shares its `bitstrobe`/`tx_strobe`/`curr_sample`. Its `tx_busy` output feeds the receiver.

---
 rtl/can_transmitter.sv | 249 ++++++++++++++++++++++++
 tb/tb_can_transmitter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_transmitter.sv
// CAN 2.0A/B transmit serializer: stuffing, CRC-15, arbitration, ACK check, error flag.
// Optional CAN_TX_RETRY_EN: failed frames are re-sent from the latched copy.
module can_transmitter #(
  parameter int IFS_BITS = 3
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        tx_strobe,
  input  logic        bitstrobe,
  input  logic        curr_sample,
  input  logic        bus_idle,
  input  logic        tx_req,
  input  logic [28:0] ID,
  input  logic        EXT,
  input  logic        RTR,
  input  logic [3:0]  pkt_size,
  input  logic [31:0] data_L,
  input  logic [31:0] data_H,
  output logic        CANTX,
  output logic        tx_busy,
  output logic        tx_ack,
  output logic        tx_done,
  output logic        arb_lost,
  output logic        bit_error,
  output logic        ack_error
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ARB     = 4'd1;
  localparam logic [3:0] S_CTRL    = 4'd2;
  localparam logic [3:0] S_DATA    = 4'd3;
  localparam logic [3:0] S_CRC     = 4'd4;
  localparam logic [3:0] S_CRC_DEL = 4'd5;
  localparam logic [3:0] S_ACK     = 4'd6;
  localparam logic [3:0] S_ACK_DEL = 4'd7;
  localparam logic [3:0] S_EOF     = 4'd8;
  localparam logic [3:0] S_IFS     = 4'd9;
  localparam logic [3:0] S_ERR     = 4'd10;

  // state/cnt name the next field bit to transmit; cur_* describe the bit now on the bus
  logic [3:0]  state;
  logic [6:0]  cnt;
  logic [14:0] crc;
  logic [2:0]  scnt;
  logic        last, stf_en;
  logic        cur_arb, cur_ack, cur_chk;
  logic        arb_pend, err_pend;
  logic [28:0] id_q;
  logic        ext_q, rtr_q;
  logic [3:0]  dlc_q;
  logic [63:0] dat_q;

  logic        fbit;
  logic [6:0]  len;
  logic [3:0]  nxt_state;
  logic [4:0]  ix;
  logic [3:0]  nbytes;
  logic        lose, aerr, berr, arb_now, err_now;
  logic        idle, start, take;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
  endfunction

  assign idle    = (state == S_IDLE);
  assign tx_busy = ~idle;
  assign nbytes  = dlc_q[3] ? 4'd8 : dlc_q;

  assign lose    = bitstrobe & cur_arb & CANTX & ~curr_sample & ~arb_pend & ~err_pend;
  assign aerr    = bitstrobe & cur_ack & curr_sample & ~err_pend;
  assign berr    = bitstrobe & cur_chk & (curr_sample ^ CANTX) & ~lose & ~arb_pend & ~err_pend;
  assign arb_now = arb_pend | lose;
  assign err_now = err_pend | aerr | berr;

`ifdef CAN_TX_RETRY_EN
  logic retry;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)                   retry <= 1'b0;
    else if (lose | aerr | berr) retry <= 1'b1;
    else if (start)              retry <= 1'b0;
  end
  assign start = tx_strobe & idle & bus_idle & (tx_req | retry);
  assign take  = start & ~retry;
`else
  assign start = tx_strobe & idle & bus_idle & tx_req;
  assign take  = start;
`endif

  always_comb begin
    fbit      = 1'b1;
    len       = 7'd1;
    nxt_state = S_IDLE;
    ix        = '0;
    case (state)
      S_ARB: begin
        len       = ext_q ? 7'd33 : 7'd14;
        nxt_state = S_CTRL;
        if (cnt == 7'd0) fbit = 1'b0;
        else if (!ext_q) begin
          if (cnt <= 7'd11) begin ix = 5'd11 - cnt[4:0]; fbit = id_q[ix]; end
          else if (cnt == 7'd12) fbit = rtr_q;
          else fbit = 1'b0;
        end else begin
          if (cnt <= 7'd11) begin ix = 5'd29 - cnt[4:0]; fbit = id_q[ix]; end
          else if (cnt <= 7'd13) fbit = 1'b1;
          else if (cnt <= 7'd31) begin ix = 5'd31 - cnt[4:0]; fbit = id_q[ix]; end
          else fbit = rtr_q;
        end
      end
      S_CTRL: begin
        // std: r0 + DLC, ext: r1 r0 + DLC
        len       = ext_q ? 7'd6 : 7'd5;
        nxt_state = (rtr_q || dlc_q == 4'd0) ? S_CRC : S_DATA;
        ix        = cnt[4:0] - (ext_q ? 5'd2 : 5'd1);
        fbit      = (cnt[4:0] < (ext_q ? 5'd2 : 5'd1)) ? 1'b0 : dlc_q[~ix[1:0]];
      end
      S_DATA: begin
        len       = {nbytes, 3'b000};
        nxt_state = S_CRC;
        fbit      = dat_q[{cnt[5:3], ~cnt[2:0]}];
      end
      S_CRC: begin
        len       = 7'd15;
        nxt_state = S_CRC_DEL;
        fbit      = crc[4'd14 - cnt[3:0]];
      end
      S_CRC_DEL: nxt_state = S_ACK;
      S_ACK:     nxt_state = S_ACK_DEL;
      S_ACK_DEL: nxt_state = S_EOF;
      S_EOF:     begin len = 7'd7; nxt_state = S_IFS; end
      S_IFS:     len = 7'(IFS_BITS);
      S_ERR:     begin len = 7'd14; fbit = (cnt >= 7'd6); end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      crc      <= '0;
      scnt     <= '0;
      last     <= 1'b0;
      stf_en   <= 1'b0;
      cur_arb  <= 1'b0;
      cur_ack  <= 1'b0;
      cur_chk  <= 1'b0;
      arb_pend <= 1'b0;
      err_pend <= 1'b0;
      id_q     <= '0;
      ext_q    <= 1'b0;
      rtr_q    <= 1'b0;
      dlc_q    <= '0;
      dat_q    <= '0;
      CANTX    <= 1'b1;
      tx_ack   <= 1'b0;
      tx_done  <= 1'b0;
      arb_lost <= 1'b0;
      bit_error <= 1'b0;
      ack_error <= 1'b0;
    end else begin
      tx_ack    <= 1'b0;
      tx_done   <= 1'b0;
      arb_lost  <= lose;
      bit_error <= berr;
      ack_error <= aerr;
      if (lose)        arb_pend <= 1'b1;
      if (aerr | berr) err_pend <= 1'b1;
      if (tx_strobe) begin
        if (idle) begin
          if (start) begin
            if (take) begin
              id_q  <= ID;
              ext_q <= EXT;
              rtr_q <= RTR;
              dlc_q <= pkt_size;
              dat_q <= {data_H, data_L};
            end
            tx_ack  <= take;
            state   <= S_ARB;
            cnt     <= 7'd1;
            CANTX   <= 1'b0;
            crc     <= '0;
            last    <= 1'b0;
            scnt    <= 3'd1;
            stf_en  <= 1'b1;
            cur_chk <= 1'b1;
            cur_arb <= 1'b0;
            cur_ack <= 1'b0;
          end
        end else if (arb_now) begin
          state    <= S_IDLE;
          cnt      <= '0;
          CANTX    <= 1'b1;
          stf_en   <= 1'b0;
          cur_arb  <= 1'b0;
          cur_ack  <= 1'b0;
          cur_chk  <= 1'b0;
          arb_pend <= 1'b0;
          err_pend <= 1'b0;
        end else if (err_now) begin
          state    <= S_ERR;
          cnt      <= 7'd1;
          CANTX    <= 1'b0;
          stf_en   <= 1'b0;
          cur_arb  <= 1'b0;
          cur_ack  <= 1'b0;
          cur_chk  <= 1'b0;
          arb_pend <= 1'b0;
          err_pend <= 1'b0;
        end else if (stf_en && scnt == 3'd5) begin
          // stuff bit: complement, counts toward the next run, bypasses CRC
          CANTX   <= ~last;
          last    <= ~last;
          scnt    <= 3'd1;
          cur_arb <= (state == S_ARB);
          cur_ack <= 1'b0;
          cur_chk <= 1'b1;
        end else if ((state == S_IFS || state == S_ERR) && cnt == len) begin
          state   <= S_IDLE;
          cnt     <= '0;
          CANTX   <= 1'b1;
          tx_done <= (state == S_IFS);
          cur_arb <= 1'b0;
          cur_ack <= 1'b0;
          cur_chk <= 1'b0;
        end else begin
          CANTX <= fbit;
          if (stf_en) begin
            scnt <= (fbit == last) ? scnt + 3'd1 : 3'd1;
            last <= fbit;
          end
          if (state == S_ARB || state == S_CTRL || state == S_DATA) crc <= crc_step(crc, fbit);
          if (state == S_CRC_DEL) stf_en <= 1'b0;
          cur_arb <= (state == S_ARB);
          cur_ack <= (state == S_ACK);
          cur_chk <= (state != S_ACK) && (state != S_ERR);
          if (state != S_IFS && state != S_ERR && cnt + 7'd1 == len) begin
            state <= nxt_state;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_can_transmitter.sv
// Self-checking bench for can_transmitter: frames are rebuilt from CAN field rules,
// CRC by polynomial division, stuffing by run-length scan, then compared bit by bit.
module tb_can_transmitter;
  localparam int IFS = 3;

  logic        clk = 1'b0, nRST = 1'b1;
  logic        tx_strobe = 1'b0, bitstrobe = 1'b0, curr_sample = 1'b1;
  logic        bus_idle = 1'b0, tx_req = 1'b0;
  logic [28:0] ID = '0;
  logic        EXT = 1'b0, RTR = 1'b0;
  logic [3:0]  pkt_size = '0;
  logic [31:0] data_L = '0, data_H = '0;
  logic        CANTX, tx_busy, tx_ack, tx_done, arb_lost, bit_error, ack_error;

  int   n_asrt = 0, n_fail = 0;
  int   n_ack = 0, n_done = 0, n_arb = 0, n_berr = 0, n_aerr = 0;
  bit   exp_q[$];
  logic obs_q[$];
  int   ack_idx;
  logic ack_v = 1'b0;

  can_transmitter #(.IFS_BITS(IFS)) dut (
    .clk(clk), .nRST(nRST), .tx_strobe(tx_strobe), .bitstrobe(bitstrobe),
    .curr_sample(curr_sample), .bus_idle(bus_idle), .tx_req(tx_req),
    .ID(ID), .EXT(EXT), .RTR(RTR), .pkt_size(pkt_size), .data_L(data_L), .data_H(data_H),
    .CANTX(CANTX), .tx_busy(tx_busy), .tx_ack(tx_ack), .tx_done(tx_done),
    .arb_lost(arb_lost), .bit_error(bit_error), .ack_error(ack_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_ack)    n_ack++;
    if (tx_done)   n_done++;
    if (arb_lost)  n_arb++;
    if (bit_error) n_berr++;
    if (ack_error) n_aerr++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_asrt++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // reference frame: field list -> CRC by long division -> stuffing -> fixed tail
  task automatic load(input logic [28:0] id, input logic ext, input logic rtr,
                      input logic [3:0] dlc, input logic [63:0] d);
    bit u[$]; bit m[$]; logic [15:0] g; int nb, run, n; bit lastb;
    ID = id; EXT = ext; RTR = rtr; pkt_size = dlc; data_L = d[31:0]; data_H = d[63:32];
    u = {}; u.push_back(1'b0);
    if (ext) begin
      for (int i = 28; i >= 18; i--) u.push_back(id[i]);
      u.push_back(1'b1); u.push_back(1'b1);
      for (int i = 17; i >= 0; i--) u.push_back(id[i]);
      u.push_back(rtr); u.push_back(1'b0); u.push_back(1'b0);
    end else begin
      for (int i = 10; i >= 0; i--) u.push_back(id[i]);
      u.push_back(rtr); u.push_back(1'b0); u.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
    for (int b = 0; b < nb; b++)
      for (int i = 7; i >= 0; i--) u.push_back(d[8*b+i]);
    g = 16'hC599;
    m = u; repeat (15) m.push_back(1'b0);
    n = u.size();
    for (int i = 0; i < n; i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
    for (int k = 0; k < 15; k++) u.push_back(m[n+k]);
    exp_q = {}; run = 0; lastb = 1'b0;
    foreach (u[i]) begin
      if (exp_q.size() > 0 && u[i] == lastb) run++; else run = 1;
      exp_q.push_back(u[i]); lastb = u[i];
      if (run == 5) begin exp_q.push_back(!u[i]); lastb = !u[i]; run = 1; end
    end
    exp_q.push_back(1'b1);
    ack_idx = exp_q.size();
    repeat (2 + 7 + IFS) exp_q.push_back(1'b1);
    obs_q = {};
  endtask

  task automatic bit_cycle(input bit ovr, input logic ov, output logic o);
    @(negedge clk); tx_strobe = 1'b1;
    @(negedge clk); tx_strobe = 1'b0; o = CANTX;
    repeat (2) @(negedge clk);
    curr_sample = ovr ? ov : CANTX; bitstrobe = 1'b1;
    @(negedge clk); bitstrobe = 1'b0; curr_sample = CANTX;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_bits(input int from, input int to, input int force_i, input logic force_v);
    logic o;
    for (int i = from; i < to; i++) begin
      bit_cycle((i == ack_idx) || (i == force_i), (i == force_i) ? force_v : ack_v, o);
      obs_q.push_back(o);
    end
  endtask

  task automatic chk_stream(input string tag, input int n);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < n; i++)
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    if (bad != 0) $display("  %s: first differing bit index %0d", tag, first);
    chk(tag, bad, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); nRST = 1'b0;
    @(negedge clk); nRST = 1'b1;
    tx_req = 1'b0; ack_v = 1'b0;
  endtask

  task automatic send_frame(input string tag, input logic [28:0] id, input logic ext,
                            input logic rtr, input logic [3:0] dlc, input logic [63:0] d);
    int a0, d0, e0; logic o;
    load(id, ext, rtr, dlc, d);
    a0 = n_ack; d0 = n_done; e0 = n_arb + n_berr + n_aerr;
    bus_idle = 1'b1; tx_req = 1'b1;
    run_bits(0, 1, -1, 1'b0);
    tx_req = 1'b0;
    run_bits(1, exp_q.size(), -1, 1'b0);
    chk($sformatf("%s_busy_ifs", tag), tx_busy, 1);
    bit_cycle(1'b0, 1'b0, o);
    chk_stream($sformatf("%s_stream", tag), exp_q.size());
    chk($sformatf("%s_ack", tag), n_ack - a0, 1);
    chk($sformatf("%s_done", tag), n_done - d0, 1);
    chk($sformatf("%s_errs", tag), n_arb + n_berr + n_aerr - e0, 0);
    chk($sformatf("%s_idle", tag), {tx_busy, CANTX}, 2'b01);
  endtask

  initial begin
    logic o;
    logic [13:0] ef;
    logic [6:0]  hd;
    int a0, d0, k;

    #3 nRST = 1'b0;
    #4;
    chk("reset_outs", {CANTX, tx_busy, tx_ack, tx_done, arb_lost, bit_error, ack_error}, 7'b1000000);
    @(negedge clk); nRST = 1'b1;
    bus_idle = 1'b1;
    bit_cycle(1'b0, 1'b0, o);
    chk("idle_no_req", {tx_busy, o}, 2'b01);

    send_frame("std123", 29'h123, 1'b0, 1'b0, 4'd1, 64'hA5);

    send_frame("std000", 29'h000, 1'b0, 1'b0, 4'd0, 64'h0);
    for (int i = 0; i < 7; i++) hd[6-i] = obs_q[i];
    chk("std000_head", hd, 7'b0000010);

    send_frame("ext_rtr", 29'h1ABCDEF0, 1'b1, 1'b1, 4'd4, 64'h1122334455667788);
    send_frame("std_dlc12", 29'h5A5, 1'b0, 1'b0, 4'd12, 64'hFFFF0000_00FF00FF);

    for (int r = 0; r < 3; r++)
      send_frame($sformatf("rnd%0d", r), 29'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom});

    // arbitration lost on 3rd ID bit
    load(29'h7FF, 1'b0, 1'b0, 4'd2, 64'hBEEF);
    a0 = n_arb;
    bus_idle = 1'b1; tx_req = 1'b1;
    run_bits(0, 1, -1, 1'b0);
    tx_req = 1'b0;
    run_bits(1, 4, 3, 1'b0);
    chk_stream("arb_head", 4);
    chk("arb_pulse", n_arb - a0, 1);
    bus_idle = 1'b0;
    bit_cycle(1'b0, 1'b0, o);
    chk("arb_release", {tx_busy, o}, 2'b01);
    bit_cycle(1'b0, 1'b0, o);
    chk("arb_wait_idle", tx_busy, 0);
    a0 = n_ack;
    bus_idle = 1'b1;
    bit_cycle(1'b0, 1'b0, o);
`ifdef CAN_TX_RETRY_EN
    chk("arb_retry", {tx_busy, o}, 2'b10);
    chk("arb_retry_noack", n_ack - a0, 0);
`else
    chk("arb_oneshot", {tx_busy, o}, 2'b01);
`endif
    do_reset();

    // ACK slot left recessive
    load(29'h2C3, 1'b0, 1'b0, 4'd2, 64'h3C5A);
    a0 = n_aerr; d0 = n_done;
    ack_v = 1'b1;
    bus_idle = 1'b1; tx_req = 1'b1;
    run_bits(0, 1, -1, 1'b0);
    tx_req = 1'b0;
    run_bits(1, ack_idx + 1, -1, 1'b0);
    ack_v = 1'b0;
    bus_idle = 1'b0;
    chk_stream("ackerr_stream", ack_idx + 1);
    chk("ackerr_pulse", n_aerr - a0, 1);
    for (int i = 0; i < 14; i++) begin bit_cycle(1'b0, 1'b0, o); ef[13-i] = o; end
    chk("ackerr_flag", ef, 14'b00000011111111);
    chk("ackerr_busy", tx_busy, 1);
    bit_cycle(1'b0, 1'b0, o);
    chk("ackerr_idle", {tx_busy, o}, 2'b01);
    chk("ackerr_nodone", n_done - d0, 0);
    do_reset();

    // bit error forced past arbitration
    load(29'h0F0, 1'b0, 1'b0, 4'd3, 64'h123456);
    a0 = n_berr;
    bus_idle = 1'b1; tx_req = 1'b1;
    run_bits(0, 1, -1, 1'b0);
    tx_req = 1'b0;
    run_bits(1, 21, 20, !exp_q[20]);
    chk("berr_pulse", n_berr - a0, 1);
    bus_idle = 1'b0;
    bit_cycle(1'b0, 1'b0, o);
    chk("berr_flag0", {tx_busy, o}, 2'b10);
    for (k = 0; k < 13; k++) bit_cycle(1'b0, 1'b0, o);
    bit_cycle(1'b0, 1'b0, o);
    chk("berr_idle", tx_busy, 0);
    do_reset();

    // async reset in the middle of DATA
    load(29'h3AA, 1'b0, 1'b0, 4'd8, {$urandom, $urandom});
    bus_idle = 1'b1; tx_req = 1'b1;
    run_bits(0, 1, -1, 1'b0);
    tx_req = 1'b0;
    run_bits(1, 26, -1, 1'b0);
    chk_stream("rst_pre_stream", 26);
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid_outs", {CANTX, tx_busy, tx_ack, tx_done, arb_lost, bit_error, ack_error}, 7'b1000000);
    @(negedge clk); nRST = 1'b1;
    d0 = n_done;
    repeat (20) bit_cycle(1'b0, 1'b0, o);
    chk("rst_no_done", n_done - d0, 0);
    chk("rst_stay_idle", {tx_busy, CANTX}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
